// File: rtl/pc_display_scan_ctrl.sv
// Scan controller for the 4-digit 7-segment PC display.
// Optional anode blanking at slot start: define PCDISP_GHOST_BLANK_EN.
module pc_display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int HALF_PERIOD  = 250,
  parameter int DEB_CYCLES   = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        auto_mode,
  input  logic        btn_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        half_sel,
  output logic        frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(HALF_PERIOD + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(HALF_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEB_CYCLES - 1);

`ifdef PCDISP_GHOST_BLANK_EN
  localparam logic [PW-1:0] BLANK_N = PW'(BLANK_CYCLES);
`else
  localparam int unused_blank = BLANK_CYCLES;
`endif

  typedef enum logic {
    ST_AUTO,
    ST_MANUAL
  } mode_t;

  mode_t          state;
  logic [31:0]    shadow;
  logic [31:0]    disp;
  logic           disp_half;
  logic [PW-1:0]  ps;
  logic [1:0]     idx;
  logic [FW-1:0]  fcnt;
  logic [FW-1:0]  fcnt_nxt;
  logic           half_nxt;
  logic           sync0;
  logic           sync1;
  logic           deb_level;
  logic [DW-1:0]  deb_cnt;
  logic           slot_end;
  logic           frame_end;
  logic           deb_accept;
  logic           deb_rise;
  logic [15:0]    h;
  logic [3:0]     nib;
  logic [3:0]     an_nxt;
  logic [6:0]     seg_nxt;

  assign slot_end   = (ps == PS_LAST);
  assign frame_end  = slot_end && (idx == 2'd3);
  assign deb_accept = (sync1 != deb_level) && (deb_cnt == DB_LAST);
  assign deb_rise   = deb_accept && sync1;
  assign h          = disp_half ? disp[31:16] : disp[15:0];

  // Prescaler and digit index; one slot is SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      ps  <= '0;
      idx <= '0;
    end else if (slot_end) begin
      ps  <= '0;
      idx <= idx + 2'd1;
    end else begin
      ps  <= ps + 1'b1;
    end
  end

  // Shadow capture; display copy and half only move at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      disp      <= '0;
      disp_half <= 1'b0;
    end else begin
      if (pc_valid)
        shadow <= pc;
      if (frame_end) begin
        disp      <= shadow;
        disp_half <= half_nxt;
      end
    end
  end

  // Two-flop synchronizer and stable-count debouncer for the button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync0 <= btn_sel;
      sync1 <= sync0;
      if (sync1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_accept) begin
        deb_level <= sync1;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Next half request and frame count for the current mode
  always_comb begin
    half_nxt = half_sel;
    fcnt_nxt = fcnt;
    unique case (state)
      ST_AUTO: begin
        if (frame_end) begin
          if (fcnt == FC_LAST) begin
            half_nxt = ~half_sel;
            fcnt_nxt = '0;
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
      end
      ST_MANUAL: begin
        fcnt_nxt = '0;
        if (deb_rise)
          half_nxt = ~half_sel;
      end
      default: begin
        half_nxt = half_sel;
        fcnt_nxt = fcnt;
      end
    endcase
  end

  // Half-select mode machine; mode follows auto_mode every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_MANUAL;
      half_sel <= 1'b0;
      fcnt     <= '0;
    end else begin
      state    <= auto_mode ? ST_AUTO : ST_MANUAL;
      half_sel <= half_nxt;
      fcnt     <= fcnt_nxt;
    end
  end

  // Digit nibble and anode pattern for the current index
  always_comb begin
    nib    = h[15:12];
    an_nxt = 4'b1110;
    unique case (idx)
      2'd0: begin nib = h[15:12]; an_nxt = 4'b1110; end
      2'd1: begin nib = h[11:8];  an_nxt = 4'b1101; end
      2'd2: begin nib = h[7:4];   an_nxt = 4'b1011; end
      2'd3: begin nib = h[3:0];   an_nxt = 4'b0111; end
      default: begin nib = h[15:12]; an_nxt = 4'b1110; end
    endcase
`ifdef PCDISP_GHOST_BLANK_EN
    if (ps < BLANK_N)
      an_nxt = 4'b1111;
`endif
  end

  // Hex to active-low gfedcba
  always_comb begin
    seg_nxt = 7'b1111111;
    unique case (nib)
      4'h0: seg_nxt = 7'b1000000;
      4'h1: seg_nxt = 7'b1111001;
      4'h2: seg_nxt = 7'b0100100;
      4'h3: seg_nxt = 7'b0110000;
      4'h4: seg_nxt = 7'b0011001;
      4'h5: seg_nxt = 7'b0010010;
      4'h6: seg_nxt = 7'b0000010;
      4'h7: seg_nxt = 7'b1111000;
      4'h8: seg_nxt = 7'b0000000;
      4'h9: seg_nxt = 7'b0010000;
      4'hA: seg_nxt = 7'b0001000;
      4'hB: seg_nxt = 7'b0000011;
      4'hC: seg_nxt = 7'b1000110;
      4'hD: seg_nxt = 7'b0100001;
      4'hE: seg_nxt = 7'b0000110;
      4'hF: seg_nxt = 7'b0001110;
      default: seg_nxt = 7'b1111111;
    endcase
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_pc_display_scan_ctrl.sv
// Directed bench for pc_display_scan_ctrl.
// Small scan/debounce parameters keep frames short.
module tb_pc_display_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        auto_mode;
  logic        btn_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        half_sel;
  logic        frame_tick;

  int n_chk;
  int n_fail;

  pc_display_scan_ctrl #(
    .SCAN_DIV    (4),
    .HALF_PERIOD (2),
    .DEB_CYCLES  (3),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .auto_mode (auto_mode),
    .btn_sel   (btn_sel),
    .an        (an),
    .seg       (seg),
    .half_sel  (half_sel),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [27:0] segs;
  } vec_t;

  vec_t vecs [5];

  localparam logic [27:0] S_ABCD = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
  localparam logic [27:0] S_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] S_8765 = {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
  localparam logic [27:0] S_0000 = {4{7'b1000000}};
  localparam logic [27:0] S_8888 = {4{7'b0000000}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc = v;
    pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_tick: frame_tick stayed 0, required 1 within 40 cycles");
    end
  endtask

  task automatic check_frame(input logic [27:0] segs, input bit inject);
    logic [3:0] an_tab [4];
    logic [3:0] ea;
    logic [6:0] es;
    int n;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        n = k * 4 + j;
        @(negedge clk);
        ea = an_tab[k];
`ifdef PCDISP_GHOST_BLANK_EN
        if (j == 0) ea = 4'b1111;
`endif
        es = segs[27 - 7 * k -: 7];
        chk($sformatf("an[d%0d c%0d]", k, j), {28'd0, an}, {28'd0, ea});
        chk($sformatf("seg[d%0d c%0d]", k, j), {25'd0, seg}, {25'd0, es});
        chk($sformatf("frame_tick[n%0d]", n), {31'd0, frame_tick},
            {31'd0, (n == 15)});
        if (inject) begin
          if (n == 4) begin pc = 32'hFFFF0000; pc_valid = 1'b1; end
          if (n == 5) pc_valid = 1'b0;
          if (n == 8) begin pc = 32'h00008888; pc_valid = 1'b1; end
          if (n == 9) pc_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    pc = '0;
    pc_valid = 1'b0;
    auto_mode = 1'b0;
    btn_sel = 1'b0;

    vecs[0] = '{32'h1234ABCD, S_ABCD};
    vecs[1] = '{32'h00000123, {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000}};
    vecs[2] = '{32'h00004567, {7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}};
    vecs[3] = '{32'h000089EF, {7'b0000000, 7'b0010000, 7'b0000110, 7'b0001110}};
    vecs[4] = '{32'h87650000, S_0000};

    repeat (2) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_half", {31'd0, half_sel}, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_pc(vecs[v].pc);
      wait_tick();
      wait_tick();
      check_frame(vecs[v].segs, 1'b0);
    end

    btn_sel = 1'b1;
    @(negedge clk);
    btn_sel = 1'b0;
    repeat (8) @(negedge clk);
    chk("pulse1_half", {31'd0, half_sel}, 32'd0);
    btn_sel = 1'b1;
    repeat (2) @(negedge clk);
    btn_sel = 1'b0;
    repeat (8) @(negedge clk);
    chk("pulse2_half", {31'd0, half_sel}, 32'd0);

    btn_sel = 1'b1;
    repeat (6) @(negedge clk);
    chk("press_half", {31'd0, half_sel}, 32'd1);
    repeat (6) @(negedge clk);
    chk("hold_half", {31'd0, half_sel}, 32'd1);
    btn_sel = 1'b0;
    repeat (8) @(negedge clk);
    chk("release_half", {31'd0, half_sel}, 32'd1);
    wait_tick();
    check_frame(S_8765, 1'b0);

    btn_sel = 1'b1;
    repeat (6) @(negedge clk);
    chk("repress_half", {31'd0, half_sel}, 32'd0);
    btn_sel = 1'b0;
    repeat (6) @(negedge clk);
    wait_tick();
    check_frame(S_0000, 1'b0);

    load_pc(32'h1234ABCD);
    wait_tick();
    wait_tick();
    auto_mode = 1'b1;
    check_frame(S_ABCD, 1'b0);
    chk("auto_t1_half", {31'd0, half_sel}, 32'd0);
    check_frame(S_ABCD, 1'b0);
    chk("auto_t2_half", {31'd0, half_sel}, 32'd1);
    check_frame(S_1234, 1'b0);
    chk("auto_t3_half", {31'd0, half_sel}, 32'd1);
    check_frame(S_1234, 1'b0);
    chk("auto_t4_half", {31'd0, half_sel}, 32'd0);
    auto_mode = 1'b0;

    check_frame(S_ABCD, 1'b1);
    check_frame(S_8888, 1'b0);

    btn_sel = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_half", {31'd0, half_sel}, 32'd1);
    btn_sel = 1'b0;
    wait_tick();
    repeat (10) @(negedge clk);
    chk("pre_rst_an", {28'd0, an}, 32'hB);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", {28'd0, an}, 32'hF);
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    chk("midrst_tick", {31'd0, frame_tick}, 32'd0);
    chk("midrst_half", {31'd0, half_sel}, 32'd0);
    rst = 1'b0;
    check_frame(S_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_display_scan_ctrl.md
Name: pc_display_scan_ctrl

Overview:
- Scan controller for the board's 4-digit multiplexed 7-segment display showing the processor PC.
- Captures PC snapshots and selects the low or high 16-bit half, either by auto-toggle or by a debounced push-button.
- Time-multiplexes the four hex digits onto one shared, active-low segment bus with active-low digit anodes.
- Sits between the datapath PC register and the board display pins.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is driven (>=2)
HALF_PERIOD, 250, full scan frames between half toggles in auto mode (>=1)
DEB_CYCLES, 100000, consecutive stable cycles required to accept a button level change (>=1)
BLANK_CYCLES, 8, anode-off cycles at the start of each digit slot; used only with the optional feature (< SCAN_DIV)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
pc  in  32  current PC value
pc_valid  in  1  one-cycle strobe; capture pc into the shadow register
auto_mode  in  1  1 = auto half toggle; 0 = manual via btn_sel
btn_sel  in  1  raw, asynchronous push-button
an  out  4  digit anodes, active-low; an[0] = most significant digit
seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}
half_sel  out  1  0 = pc[15:0] shown, 1 = pc[31:16] shown
frame_tick  out  1  one-cycle pulse at the end of each 4-digit frame

Behaviour:
- Reset (rst high at a clk edge): shadow = 0, disp = 0, prescaler = 0, digit index = 0, frame counter = 0, half_sel = 0, debounced level = 0, synchronizer flops = 0, an = 4'b1111, seg = 7'b1111111, frame_tick = 0. Reset mid-frame aborts the scan immediately.
- Capture: pc_valid high loads shadow <= pc. Multiple strobes in a frame: last one wins.
- Tear-free update: disp <= shadow only on the cycle that frame_tick is generated. The displayed value changes only at frame boundaries.
- Prescaler: counts 0..SCAN_DIV-1. On wrap, digit index advances 0->1->2->3->0.
- Digit 3 wrap: frame_tick = 1 for exactly that cycle, and the frame counter increments.
- Digit mapping, where H = half_sel ? disp[31:16] : disp[15:0]:
  - index 0 -> H[15:12], an = 1110
  - index 1 -> H[11:8], an = 1101
  - index 2 -> H[7:4], an = 1011
  - index 3 -> H[3:0], an = 0111
- Outputs: an, seg and frame_tick are registered, one cycle of latency from the internal index/prescaler state.
- Hex decode (active-low gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Debounce:
  - btn_sel passes through a 2-flop synchronizer.
  - The debounced level changes only after the synchronized value differs from it for DEB_CYCLES consecutive cycles. Any bounce back restarts the count.
- Half select state machine, states AUTO and MANUAL, selected by auto_mode each cycle:
  - AUTO: when the frame counter reaches HALF_PERIOD together with a frame_tick, toggle half_sel and clear the frame counter. Button edges are ignored.
  - MANUAL: a debounced rising edge toggles half_sel. The frame counter is held at 0.
  - AUTO->MANUAL: half_sel is kept.
  - MANUAL->AUTO: the frame counter starts from 0.
- half_sel changes take effect only at the next frame boundary: the displayed half is latched together with disp. The half_sel port reflects the request immediately.
- Simultaneous pc_valid and frame_tick: disp takes the old shadow; the new pc is shown next frame.

Optional Feature:
- Macro: PCDISP_GHOST_BLANK_EN.
- Defined: for prescaler values 0..BLANK_CYCLES-1 of every digit slot, an = 4'b1111 (seg still driven). This suppresses ghosting on anode switches.
- Undefined: the anode is active for the whole slot; BLANK_CYCLES is unused.

Test Plan:
- Bench parameters: SCAN_DIV=4, HALF_PERIOD=2, DEB_CYCLES=3.
- Reset then release, pc_valid with pc=0x1234ABCD, auto_mode=0 -> after the first frame_tick, an sequence 1110,1101,1011,0111 with seg A,b,C,d (0001000, 0000011, 1000110, 0100001), 4 cycles each.
- auto_mode=1 -> half_sel toggles after every 2 frame_ticks; the following frame shows 1,2,3,4 (1111001, 0100100, 0110000, 0011001).
- btn_sel pulses of 1-2 cycles in manual mode -> no half_sel change. Held for >=3+2 cycles -> exactly one toggle; release and re-press -> toggles back.
- pc_valid with 0xFFFF0000 mid-frame, then 0x00008888 before the frame end -> the next frame shows 8888 only, with no mixed digits.
- rst asserted during digit index 2 -> the next cycle shows an=1111, seg=1111111, half_sel=0. The scan restarts at digit 0 and displays 0000.
- With PCDISP_GHOST_BLANK_EN and BLANK_CYCLES=1 -> the first cycle of every slot has an=1111, and the remaining 3 cycles have the correct anode.
